// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two writeback FIFOs (ALU, LSU) round-robin arbitrated onto the single regfile write port
// Optional feature macro WB_PENDING_MASK_EN builds the per-register pending-write mask used for decode hazard stalls;
// when undefined, pending_mask_o is tied to zero.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic            s0_valid_i,
  output logic            s0_ready_o,
  input  logic [4:0]      s0_rd_i,
  input  logic [XLEN-1:0] s0_data_i,
  input  logic            s1_valid_i,
  output logic            s1_ready_o,
  input  logic [4:0]      s1_rd_i,
  input  logic [XLEN-1:0] s1_data_i,
  output logic            rf_reg_write_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic [31:0]     pending_mask_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [1:0]           in_valid, ready, pop, ne;
  logic [1:0][4:0]      in_rd, head_rd;
  logic [1:0][XLEN-1:0] in_data, head_data;
  logic                 last_grant_q, gnt_any, gsel;
  logic                 rf_we_q;
  logic [4:0]           rf_rd_q;
  logic [XLEN-1:0]      rf_data_q;
`ifdef WB_PENDING_MASK_EN
  logic [1:0][31:0]     fifo_mask;
`endif
  assign in_valid       = {s1_valid_i, s0_valid_i};
  assign in_rd          = {s1_rd_i, s0_rd_i};
  assign in_data        = {s1_data_i, s0_data_i};
  assign s0_ready_o     = ready[0];
  assign s1_ready_o     = ready[1];
  assign rf_reg_write_o = rf_we_q;
  assign rf_rd_o        = rf_rd_q;
  assign rf_data_o      = rf_data_q;
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept, push;
    assign ready[g]     = cnt_q != CW'(DEPTH);
    assign accept       = in_valid[g] & ready[g];
    assign push         = accept & (in_rd[g] != 5'd0);
    assign ne[g]        = cnt_q != '0;
    assign head_rd[g]   = rd_q[rptr_q];
    assign head_data[g] = data_q[rptr_q];
    // pointer/count advance; x0 writes complete the handshake but never occupy a slot
    always_comb begin
      wptr_d = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d = pop[g] ? rptr_q + AW'(1) : rptr_q;
      cnt_d  = cnt_q + CW'(push) - CW'(pop[g]);
    end
    // queue bookkeeping, cleared asynchronously so reset drops every queued write
    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        rptr_q <= rptr_d;
        wptr_q <= wptr_d;
        cnt_q  <= cnt_d;
      end
    end
    // slot storage; validity comes from the count, so no reset is needed
    always_ff @(posedge clock_i) begin
      if (push) begin
        rd_q[wptr_q]   <= in_rd[g];
        data_q[wptr_q] <= in_data[g];
      end
    end
`ifdef WB_PENDING_MASK_EN
    logic [31:0] mask;
    // decode the destination of every occupied slot
    always_comb begin
      mask = '0;
      for (int i = 0; i < DEPTH; i++)
        if ({1'b0, AW'(i) - rptr_q} < cnt_q) mask = mask | (32'd1 << rd_q[i]);
    end
    assign fifo_mask[g] = mask;
`endif
  end
  // round-robin pick: alternate on contention, otherwise take whichever source has work
  always_comb begin
    gnt_any = |ne;
    gsel    = &ne ? ~last_grant_q : ne[1];
    pop     = {gnt_any & gsel, gnt_any & ~gsel};
  end
  // registered write port; rd/data hold when idle, last_grant moves only on a grant
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_data_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rf_we_q <= gnt_any;
      if (gnt_any) begin
        rf_rd_q      <= head_rd[gsel];
        rf_data_q    <= head_data[gsel];
        last_grant_q <= gsel;
      end
    end
  end
`ifdef WB_PENDING_MASK_EN
  // queued writes plus the one being presented; x0 is never pending
  always_comb pending_mask_o = (fifo_mask[0] | fifo_mask[1] | (rf_we_q ? 32'd1 << rf_rd_q : 32'd0)) & ~32'd1;
`else
  assign pending_mask_o = 32'd0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of reset, latency, contention order, backpressure and x0 drop
module tb_regfile_wb_arbiter;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;
`ifdef WB_PENDING_MASK_EN
  localparam bit PM = 1'b1;
`else
  localparam bit PM = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        s0_valid, s0_ready, s1_valid, s1_ready, rf_reg_write;
  logic [4:0]  s0_rd, s1_rd, rf_rd;
  logic [31:0] s0_data, s1_data, rf_data, pending_mask;
  int          errors = 0, checks = 0;
  ent_t        q0[$], q1[$], got[$];
  int          got_cyc[$], exp_rd[$];
  logic        rdy1_hist[$];
  regfile_wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .s0_valid_i(s0_valid), .s0_ready_o(s0_ready), .s0_rd_i(s0_rd), .s0_data_i(s0_data),
    .s1_valid_i(s1_valid), .s1_ready_o(s1_ready), .s1_rd_i(s1_rd), .s1_data_i(s1_data),
    .rf_reg_write_o(rf_reg_write), .rf_rd_o(rf_rd), .rf_data_o(rf_data), .pending_mask_o(pending_mask)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic ent_t mk(input int r);
    return ent_t'({5'(r), 32'hC0DE_0000 | 32'(r)});
  endfunction
  task automatic drive(input string tag, input int budget);
    int   cyc = 0;
    logic a0, a1;
    got.delete();
    got_cyc.delete();
    rdy1_hist.delete();
    while ((q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
      s0_valid = q0.size() != 0;
      s1_valid = q1.size() != 0;
      if (s0_valid) begin s0_rd = q0[0].rd; s0_data = q0[0].data; end
      if (s1_valid) begin s1_rd = q1[0].rd; s1_data = q1[0].data; end
      rdy1_hist.push_back(s1_ready);
      a0 = s0_valid && s0_ready;
      a1 = s1_valid && s1_ready;
      @(negedge clk);
      cyc++;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      if (rf_reg_write) begin got.push_back(ent_t'({rf_rd, rf_data})); got_cyc.push_back(cyc); end
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    chk({tag, "_drain"}, 64'(cyc < budget), 64'd1);
    repeat (6) begin
      @(negedge clk);
      cyc++;
      if (rf_reg_write) begin got.push_back(ent_t'({rf_rd, rf_data})); got_cyc.push_back(cyc); end
    end
  endtask
  task automatic check_got(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_rd.size()));
    foreach (exp_rd[i]) if (i < got.size()) begin
      chk($sformatf("%s_rd%0d", tag, i), 64'(got[i].rd), 64'(exp_rd[i]));
      chk($sformatf("%s_data%0d", tag, i), 64'(got[i].data), 64'(32'hC0DE_0000 | 32'(exp_rd[i])));
      chk($sformatf("%s_cyc%0d", tag, i), 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    end
  endtask
  initial begin
    int n;
    s0_valid = 0; s1_valid = 0; s0_rd = 0; s1_rd = 0; s0_data = 0; s1_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_we", 64'(rf_reg_write), 64'd0);
    chk("rst_rd", 64'(rf_rd), 64'd0);
    chk("rst_data", 64'(rf_data), 64'd0);
    chk("rst_rdy0", 64'(s0_ready), 64'd1);
    chk("rst_rdy1", 64'(s1_ready), 64'd1);
    chk("rst_pm", 64'(pending_mask), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // contention: src0 wins first tie, then strict alternation
    for (int i = 1; i <= 3; i++) begin q0.push_back(mk(i)); q1.push_back(mk(i + 9)); end
    drive("cont", 40);
    exp_rd = '{1, 10, 2, 11, 3, 12};
    check_got("cont");
    if (got_cyc.size() != 0) chk("cont_first_cyc", 64'(got_cyc[0]), 64'd2);
    // backpressure on src1 while src0 saturates
    for (int i = 20; i <= 23; i++) q0.push_back(mk(i));
    for (int i = 7; i <= 9; i++) q1.push_back(mk(i));
    drive("bp", 40);
    exp_rd = '{20, 7, 21, 8, 22, 9, 23};
    check_got("bp");
    chk("bp_rdy1_c0", 64'(rdy1_hist[0]), 64'd1);
    chk("bp_rdy1_c1", 64'(rdy1_hist[1]), 64'd1);
    chk("bp_rdy1_c2", 64'(rdy1_hist[2]), 64'd0);
    chk("bp_rdy1_c3", 64'(rdy1_hist[3]), 64'd1);
    // x0: accepted, never written
    q0.push_back(ent_t'({5'd0, 32'h1234}));
    drive("x0", 10);
    exp_rd.delete();
    check_got("x0");
    chk("x0_pm", 64'(pending_mask), 64'd0);
    chk("x0_rdy0", 64'(s0_ready), 64'd1);
    // reset mid-burst with 3 entries queued and one being presented
    s0_valid = 1; s0_rd = 3; s0_data = mk(3).data;
    s1_valid = 1; s1_rd = 6; s1_data = mk(6).data;
    @(negedge clk);
    s0_rd = 4; s0_data = mk(4).data;
    s1_rd = 7; s1_data = mk(7).data;
    @(negedge clk);
    s0_valid = 0; s1_valid = 0;
    chk("mid_we", 64'(rf_reg_write), 64'd1);
    chk("mid_rd", 64'(rf_rd), 64'd6);
    chk("mid_pm", 64'(pending_mask), PM ? 64'h00D8 : 64'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(rf_reg_write), 64'd0);
    chk("mid_rst_rd", 64'(rf_rd), 64'd0);
    chk("mid_rst_data", 64'(rf_data), 64'd0);
    chk("mid_rst_rdy0", 64'(s0_ready), 64'd1);
    chk("mid_rst_rdy1", 64'(s1_ready), 64'd1);
    chk("mid_rst_pm", 64'(pending_mask), 64'd0);
    @(negedge clk);
    chk("mid_rst_we2", 64'(rf_reg_write), 64'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (rf_reg_write) n++; end
    chk("mid_no_write", 64'(n), 64'd0);
    // single write latency and pending window
    s0_valid = 1; s0_rd = 5; s0_data = 32'hDEADBEEF;
    chk("single_rdy0", 64'(s0_ready), 64'd1);
    @(negedge clk);
    s0_valid = 0;
    chk("single_we0", 64'(rf_reg_write), 64'd0);
    chk("single_pm0", 64'(pending_mask), PM ? 64'h20 : 64'h0);
    @(negedge clk);
    chk("single_we1", 64'(rf_reg_write), 64'd1);
    chk("single_rd1", 64'(rf_rd), 64'd5);
    chk("single_data1", 64'(rf_data), 64'hDEADBEEF);
    chk("single_pm1", 64'(pending_mask), PM ? 64'h20 : 64'h0);
    @(negedge clk);
    chk("single_we2", 64'(rf_reg_write), 64'd0);
    chk("single_pm2", 64'(pending_mask), 64'd0);
    chk("single_rd_hold", 64'(rf_rd), 64'd5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
